// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - instruction store, fetch register and field decoder
// Optional IFD_PARITY_EN: per-word even parity, checked on fetch, with a parity_inject test port.
module instr_fetch_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_we,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic        load_done,
  input  logic        clear,
  input  logic        insbuf_en,
  input  logic        decoder_en,
  input  logic [7:0]  pc,
`ifdef IFD_PARITY_EN
  input  logic        parity_inject,
`endif
  output logic [3:0]  func,
  output logic [9:0]  rs1,
  output logic [9:0]  rs2,
  output logic [3:0]  opcode,
  output logic        prog_ready,
  output logic        halted,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        load_reject
);
  localparam logic [1:0]  S_LOAD    = 2'd0;
  localparam logic [1:0]  S_RUN     = 2'd1;
  localparam logic [1:0]  S_HALTED  = 2'd2;
  localparam logic [1:0]  E_NONE    = 2'd0;
  localparam logic [1:0]  E_ILLEGAL = 2'd1;
  localparam logic [1:0]  E_RANGE   = 2'd2;
  localparam logic [27:0] HALT_WORD = 28'hF00000F;

`ifdef IFD_PARITY_EN
  localparam int MW = 29;
`else
  localparam int MW = 28;
`endif

  logic [MW-1:0] mem [0:255];
  logic [1:0]    state;
  logic [8:0]    prog_len;
  logic [8:0]    addr_len;
  logic [8:0]    next_len;
  logic [27:0]   fetch_reg;
  logic [1:0]    pend_code;
  logic [MW-1:0] wr_word;
  logic [MW-1:0] rd_word;
  logic [27:0]   fetch_next;
  logic [1:0]    fetch_code;
  logic [7:0]    fo;
  logic          legal;
  logic          unused_reserved;

  assign unused_reserved = ^load_data[31:28];
  assign prog_ready      = (state == S_RUN);
  assign halted          = (state == S_HALTED);

`ifdef IFD_PARITY_EN
  assign wr_word = {(^load_data[27:0]) ^ parity_inject, load_data[27:0]};
`else
  assign wr_word = load_data[27:0];
`endif

  // Program length covers the highest address written, including a write coincident with load_done.
  assign addr_len = {1'b0, load_addr} + 9'd1;
  assign next_len = (load_we && (addr_len > prog_len)) ? addr_len : prog_len;

  always_comb begin
    rd_word    = mem[pc];
    fetch_next = rd_word[27:0];
    fetch_code = E_NONE;
    if ({1'b0, pc} >= prog_len) begin
      fetch_next = HALT_WORD;
      fetch_code = E_RANGE;
    end
`ifdef IFD_PARITY_EN
    else if (^rd_word) begin
      fetch_next = HALT_WORD;
      fetch_code = 2'd3;
    end
`endif
  end

  always_comb begin
    fo    = {fetch_reg[27:24], fetch_reg[3:0]};
    legal = (fo == 8'h12) || (fo == 8'h22) || (fo == 8'h11) ||
            (fo == 8'h14) || (fo == 8'hFF);
  end

  // Memory has no reset so program images survive reset and clear.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && load_we && !clear)
      mem[load_addr] <= wr_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_LOAD;
      prog_len    <= 9'd0;
      fetch_reg   <= 28'd0;
      pend_code   <= E_NONE;
      {func, rs1, rs2, opcode} <= 28'd0;
      err         <= 1'b0;
      err_code    <= E_NONE;
      load_reject <= 1'b0;
    end else if (clear) begin
      state       <= S_LOAD;
      prog_len    <= 9'd0;
      fetch_reg   <= 28'd0;
      pend_code   <= E_NONE;
      {func, rs1, rs2, opcode} <= 28'd0;
      err         <= 1'b0;
      err_code    <= E_NONE;
      load_reject <= 1'b0;
    end else begin
      if (load_we && state != S_LOAD)
        load_reject <= 1'b1;
      case (state)
        S_LOAD: begin
          prog_len <= next_len;
          if (load_done && next_len != 9'd0)
            state <= S_RUN;
        end
        S_RUN: begin
          if (insbuf_en) begin
            fetch_reg <= fetch_next;
            pend_code <= fetch_code;
          end
          // Decode sees the pre-edge fetch_reg, so a same-cycle fetch does not race it.
          if (decoder_en) begin
            if (pend_code != E_NONE) begin
              {func, rs1, rs2, opcode} <= HALT_WORD;
              state <= S_HALTED;
              err   <= 1'b1;
              if (!err) err_code <= pend_code;
            end else if (legal) begin
              {func, rs1, rs2, opcode} <= fetch_reg;
              if (fo == 8'hFF) state <= S_HALTED;
            end else begin
              {func, rs1, rs2, opcode} <= HALT_WORD;
              state <= S_HALTED;
              err   <= 1'b1;
              if (!err) err_code <= E_ILLEGAL;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
